instr_fetch_stage: RTL and testbench

- Fetch stage directly upstream of the operand-select controller: owns the program counter, reads 16-bit instruction words from instruction memory, and holds the current word in an instruction register.
- Drives op[15:0], which feeds the selector controller and the decoder, using a valid/ready handshake.
- Supports branch redirect from the execute stage and halts after delivering an HLT instruction.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_reg.sv | 25 ++
 rtl/instr_fetch_stage.sv | 131 +++++++++++++
 tb/tb_instr_fetch_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, opcode-field constants
// and the HLT decode helper used by fetch, selector controller and decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [1:0] OPC_ALU = 2'b11;
  localparam logic [1:0] OPC_BR  = 2'b10;
  localparam logic [1:0] OPC_LD  = 2'b00;
  localparam logic [1:0] OPC_ST  = 2'b01;

  localparam logic [3:0] HLT_OP3_DEFAULT = 4'b1111;

  // HLT is an ALU-class word whose op3 field carries the halt code.
  function automatic logic is_hlt(input logic [15:0] op,
                                  input logic [3:0]  op3 = HLT_OP3_DEFAULT);
    return (op[15:14] == OPC_ALU) && (op[7:4] == op3);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset, load (redirect) and increment, with load
// taking priority over increment. Increment wraps modulo 2^ADDR_W.
module pc_reg #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, imem read handshake, instruction register with
// valid/ready output, branch redirect and HLT/resume. Optional performance
// counters are enabled with the IF_PERF_CNT_EN macro.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HLT_OP3  = HLT_OP3_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       op,
  output logic [ADDR_W-1:0] op_pc,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              resume,
  output logic              halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc, op_load, vld_clr;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (br_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc;
  assign halted    = (state_q == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect outranks ack/ready in FETCH and HOLD; HALT only listens to resume.
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    op_load = 1'b0;
    vld_clr = 1'b0;
    case (state_q)
      FETCH: begin
        if (br_taken) begin
          pc_load = 1'b1;
        end else if (imem_ack) begin
          op_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_load = 1'b1;
          vld_clr = 1'b1;
          state_d = FETCH;
        end else if (op_ready) begin
          vld_clr = 1'b1;
          state_d = is_hlt(op, HLT_OP3) ? HALT : FETCH;
        end
      end
      HALT: begin
        if (resume) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op       <= 16'h0000;
      op_pc    <= '0;
      op_valid <= 1'b0;
    end else if (op_load) begin
      op       <= imem_rdata;
      op_pc    <= pc;
      op_valid <= 1'b1;
    end else if (vld_clr) begin
      op_valid <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic stall_inc;
  // Nothing increments in HALT, so the counters freeze there naturally.
  assign stall_inc = ((state_q == FETCH) && !imem_ack) ||
                     ((state_q == HOLD)  && !op_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (op_load && (fetch_cnt != 32'hFFFF_FFFF)) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (stall_inc && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: wait-state memory model, scoreboard of
// accepted fetches checked against each op_valid rise, plus directed checks.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] op;
  logic [15:0] op_pc;
  logic        op_valid;
  logic        op_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic        resume;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:255];
  logic        mem_en;
  int          ws;
  int          wait_cnt;
  logic [31:0] sb_q [$];
  logic        op_valid_prev = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .op         (op),
    .op_pc      (op_pc),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .resume     (resume),
    .halted     (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Memory answers after ws cycles of a held request.
  assign imem_ack   = mem_en && imem_req && (wait_cnt >= ws);
  assign imem_rdata = mem[imem_addr[7:0]];

  always @(posedge clk) begin
    if (!rst_n || !imem_req || imem_ack) wait_cnt <= 0;
    else                                 wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) sb_q.delete();
    else if (imem_req && imem_ack && !br_taken) sb_q.push_back({imem_addr, imem_rdata});
  end

  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (op_valid && !op_valid_prev) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_op_pc_op", {op_pc, op}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("sb_op", {16'h0, op}, {16'h0, e[15:0]});
        chk("sb_op_pc", {16'h0, op_pc}, {16'h0, e[31:16]});
      end
    end
    op_valid_prev = op_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'hC0A0; mem[1] = 16'h8123; mem[2] = 16'h1234;
    mem[5] = 16'hC0F0; mem[6] = 16'hC0F0; mem[8'h40] = 16'h4321;
    rst_n = 1'b0; op_ready = 1'b0; br_taken = 1'b0; br_target = 16'h0;
    resume = 1'b0; mem_en = 1'b1; ws = 0;
    step(2);
    chk("rst_op_valid", {31'h0, op_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_op", {16'h0, op}, 32'h0);
    chk("rst_op_pc", {16'h0, op_pc}, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h1);
    chk("rst_imem_addr", {16'h0, imem_addr}, 32'h0);

    // Zero-wait back-to-back fetches
    op_ready = 1'b1; rst_n = 1'b1;
    chk("s1_c1_addr", {16'h0, imem_addr}, 32'h0);
    step(1);
    chk("s1_c2_valid", {31'h0, op_valid}, 32'h1);
    chk("s1_c2_op", {16'h0, op}, 32'h0000_C0A0);
    step(1);
    chk("s1_c3_addr", {16'h0, imem_addr}, 32'h1);
    chk("s1_c3_req", {31'h0, imem_req}, 32'h1);
    step(1);
    chk("s1_c4_op", {16'h0, op}, 32'h0000_8123);
    chk("s1_c4_op_pc", {16'h0, op_pc}, 32'h1);

    // Downstream back-pressure in HOLD
    op_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("s3_op", {16'h0, op}, 32'h0000_8123);
      chk("s3_op_pc", {16'h0, op_pc}, 32'h1);
      chk("s3_valid", {31'h0, op_valid}, 32'h1);
      chk("s3_req", {31'h0, imem_req}, 32'h0);
    end
    op_ready = 1'b1;
    step(1);
    chk("s3_refetch_req", {31'h0, imem_req}, 32'h1);
    chk("s3_refetch_addr", {16'h0, imem_addr}, 32'h2);
    chk("s3_refetch_valid", {31'h0, op_valid}, 32'h0);
    step(1);
    chk("s3_op2", {16'h0, op}, 32'h0000_1234);

    // Reset while HOLD holds a live op
    op_ready = 1'b0; rst_n = 1'b0;
    step(1);
    chk("rst_hold_valid", {31'h0, op_valid}, 32'h0);
    chk("rst_hold_halted", {31'h0, halted}, 32'h0);
    chk("rst_hold_addr", {16'h0, imem_addr}, 32'h0);

    // Three wait states
    ws = 3; op_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step(1);
      chk("s2_req", {31'h0, imem_req}, 32'h1);
      chk("s2_addr", {16'h0, imem_addr}, 32'h0);
      chk("s2_valid_low", {31'h0, op_valid}, 32'h0);
    end
    step(1);
    chk("s2_valid", {31'h0, op_valid}, 32'h1);
`ifdef IF_PERF_CNT_EN
    chk("s2_fetch_cnt", fetch_cnt, 32'd1);
    chk("s2_stall_cnt", stall_cnt, 32'd3);
`endif

    // Redirect in the same cycle as an ack
    ws = 0;
    step(1);
    chk("s4_addr_pre", {16'h0, imem_addr}, 32'h1);
    chk("s4_ack_pre", {31'h0, imem_ack}, 32'h1);
    br_taken = 1'b1; br_target = 16'h0040;
    step(1);
    br_taken = 1'b0;
    chk("s4_valid", {31'h0, op_valid}, 32'h0);
    chk("s4_addr", {16'h0, imem_addr}, 32'h0040);
    step(1);
    chk("s4_op", {16'h0, op}, 32'h0000_4321);

    // Redirect from HOLD to pc 5, fetch HLT, halt, resume at 6
    br_taken = 1'b1; br_target = 16'h0005;
    step(1);
    br_taken = 1'b0;
    chk("s5_addr", {16'h0, imem_addr}, 32'h5);
    step(1);
    chk("s5_hlt_op", {16'h0, op}, 32'h0000_C0F0);
    step(1);
    br_taken = 1'b1; br_target = 16'h0040;
    for (int i = 0; i < 10; i++) begin
      chk("s5_halted", {31'h0, halted}, 32'h1);
      chk("s5_req", {31'h0, imem_req}, 32'h0);
      chk("s5_valid", {31'h0, op_valid}, 32'h0);
      step(1);
    end
    br_taken = 1'b0; resume = 1'b1;
    step(1);
    resume = 1'b0;
    chk("s5_resume_addr", {16'h0, imem_addr}, 32'h6);
    chk("s5_resume_halted", {31'h0, halted}, 32'h0);
    step(2);
    chk("s6_halted_again", {31'h0, halted}, 32'h1);

    // Reset while halted
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("rst_halt_halted", {31'h0, halted}, 32'h0);
    chk("rst_halt_valid", {31'h0, op_valid}, 32'h0);
    chk("rst_halt_addr", {16'h0, imem_addr}, 32'h0);
    chk("sb_drained", sb_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
